demux16_tdm: RTL
================

Name: demux16_tdm

Overview:
- Registered 1-to-16 demultiplexer and time-division deserializer. It is the receive-side counterpart of the 16:1 select mux.
- Routes a WIDTH-bit input beat to one of 16 held channel registers. The channel is chosen either by an explicit 4-bit select (direct mode) or by an internal scan counter (scan mode).
- In scan mode, assembles 16 consecutive beats into a frame snapshot. It sits after a serial link or mux16 and presents parallel channel data to downstream logic.

Parameters:
- WIDTH, 1, bits per channel beat.
- CONTINUOUS, 0, scan mode: 1 = wrap to channel 0 and keep collecting after a frame; 0 = return to IDLE after each frame.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- d  in  WIDTH  input data beat.
- d_valid  in  1  beat qualifier.
- s  in  4  channel select, direct mode only (s[3] MSB).
- addr_mode  in  1  0 = direct, 1 = scan.
- start  in  1  scan-mode frame start/restart strobe.
- y  out  16*WIDTH  channel registers; channel k at y[k*WIDTH +: WIDTH].
- y_upd  out  16  one-hot, one-cycle write strobe per channel.
- frame  out  16*WIDTH  last completed scan frame snapshot.
- frame_valid  out  1  one-cycle pulse when frame updates.
- chan  out  4  next scan channel index.
- busy  out  1  high in SCAN state.
- err  out  1  one-cycle pulse on a dropped beat.

Behaviour:
- Reset: asynchronous on rst_n low. y, frame, y_upd, frame_valid, chan, err = 0; busy = 0; state = IDLE.
- Reset mid-frame discards the partial frame. No frame_valid follows.
- Latency: a beat accepted at edge N appears in y and on its y_upd bit after edge N. Outputs are registered; there is no combinational input-to-output path.
- Direct mode (addr_mode=0):
  - d_valid=1 writes y[s] <= d and sets y_upd = 1<<s for one cycle.
  - All other channels hold their values.
  - The FSM is forced to IDLE and chan = 0.
- Scan mode (addr_mode=1), states IDLE and SCAN:
  - IDLE: start=1 -> SCAN with chan = 0. If d_valid=1 in the same cycle, that beat is captured as channel 0 and chan becomes 1.
  - IDLE: d_valid=1 with start=0 -> beat dropped, err pulses.
  - SCAN: d_valid=1 writes y[chan], pulses y_upd[chan], then chan <= chan+1 (4-bit wrap).
  - SCAN: d_valid=0 holds everything. Gaps of any length are allowed.
  - Completion on the channel-15 write:
    - frame <= y with channel 15 replaced by the new beat.
    - frame_valid pulses on the same registered cycle as y_upd[15].
    - chan wraps to 0.
    - Next state: CONTINUOUS=1 -> SCAN; CONTINUOUS=0 -> IDLE.
  - SCAN with start=1: chan restarts at 0 and the partial frame is abandoned (y keeps the written values, frame is unchanged). A simultaneous d_valid beat goes to channel 0.
  - start=1 in direct mode is ignored.
- addr_mode toggled while in SCAN: abort to IDLE, chan = 0, no frame_valid. A beat in that cycle is handled under the new mode.
- busy = (state == SCAN).
- err is registered with a one-cycle pulse. It never blocks acceptance of subsequent beats.

Decomposition:
- Shared package demux16_pkg holds:
  - NUM_CH = 16 and CH_W = 4.
  - State enum for IDLE/SCAN.
  - Helper function chan_slice(k) returning the bit offset k*WIDTH.
- One natural sub-module: demux16_chan_reg. It is a per-channel WIDTH-bit enabled register with async active-low reset, instantiated 16 times with one-hot enables from a 4-to-16 decoder.
- FSM, counter and frame snapshot stay in the top level.

Test Plan:
- Reset: hold rst_n=0, then drive d_valid=1 with random d -> all outputs 0; release -> y=0, frame=0, busy=0.
- Direct sweep: WIDTH=1, addr_mode=0. For s = 0..15, drive d = s[0] -> y = 16'hAAAA after 16 beats; y_upd = 1<<s the cycle after each beat; frame_valid never pulses.
- Scan frame with gaps: addr_mode=1, start+d_valid together, 16 beats of pattern 0,1,0,1,... with d_valid low every third cycle -> frame = 16'hAAAA; frame_valid one pulse aligned with y_upd[15]; busy falls next cycle (CONTINUOUS=0).
- Restart and drop:
  - d_valid in IDLE without start -> err pulse, y unchanged.
  - start after 7 beats -> chan = 0, next 16 beats produce frame_valid exactly once, at the 16th post-restart beat.
- Continuous and abort:
  - CONTINUOUS=1, 40 beats -> frame_valid at beats 16 and 32, chan = 8, busy stays 1.
  - Toggle addr_mode=0 mid-frame -> busy=0, no frame_valid.
  - Async rst_n pulse mid-frame -> immediate clear, frame=0.
- Loopback: feed y into mux16 with s sweeping 0..15 after a direct-mode load of random data -> mux16 output equals the loaded bit for each s.

Source files
------------

// File: rtl/demux16_pkg.sv
// Shared constants, scan FSM state type and slice helper for the 16-channel
// demultiplexer / TDM deserializer.
package demux16_pkg;

    localparam int NUM_CH = 16;
    localparam int CH_W   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Bit offset of channel k inside a packed 16*width bus.
    function automatic int chan_slice(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/demux16_chan_reg.sv
// One held channel register: loads the shared input beat when its decoded
// enable is high, otherwise keeps its value.
module demux16_chan_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/demux16_tdm.sv
// Registered 1-to-16 demultiplexer with direct-select and scan (frame
// deserializer) addressing; scan FSM, channel counter and frame snapshot.
module demux16_tdm
    import demux16_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        d,
    input  logic                    d_valid,
    input  logic [CH_W-1:0]         s,
    input  logic                    addr_mode,
    input  logic                    start,
    output logic [NUM_CH*WIDTH-1:0] y,
    output logic [NUM_CH-1:0]       y_upd,
    output logic [NUM_CH*WIDTH-1:0] frame,
    output logic                    frame_valid,
    output logic [CH_W-1:0]         chan,
    output logic                    busy,
    output logic                    err
);

    state_t                    state_reg, state_next;
    logic [CH_W-1:0]           chan_reg, chan_next;
    logic                      wr_en;
    logic [CH_W-1:0]           wr_ch;
    logic                      err_next;
    logic                      frame_load;
    logic [NUM_CH-1:0]         ch_en;
    logic [NUM_CH*WIDTH-1:0]   y_q;

    // Direct mode always parks the scan FSM, so leaving scan mode mid-frame
    // is an abort with no frame_valid.
    always_comb begin
        state_next = state_reg;
        chan_next  = chan_reg;
        wr_en      = 1'b0;
        wr_ch      = '0;
        err_next   = 1'b0;
        frame_load = 1'b0;
        if (!addr_mode) begin
            state_next = ST_IDLE;
            chan_next  = '0;
            wr_en      = d_valid;
            wr_ch      = s;
        end else if (start) begin
            state_next = ST_SCAN;
            wr_en      = d_valid;
            wr_ch      = '0;
            chan_next  = d_valid ? CH_W'(1) : '0;
        end else if (state_reg == ST_IDLE) begin
            err_next = d_valid;
        end else if (d_valid) begin
            wr_en     = 1'b1;
            wr_ch     = chan_reg;
            chan_next = chan_reg + CH_W'(1);
            if (chan_reg == CH_W'(NUM_CH - 1)) begin
                frame_load = 1'b1;
                state_next = CONTINUOUS ? ST_SCAN : ST_IDLE;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_en[gi] = wr_en && (wr_ch == CH_W'(gi));
            demux16_chan_reg #(
                .WIDTH (WIDTH)
            ) u_chan_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (ch_en[gi]),
                .d     (d),
                .q     (y_q[chan_slice(gi, WIDTH) +: WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            chan_reg    <= '0;
            y_upd       <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            frame       <= '0;
        end else begin
            state_reg   <= state_next;
            chan_reg    <= chan_next;
            y_upd       <= ch_en;
            frame_valid <= frame_load;
            err         <= err_next;
            if (frame_load) begin
                frame <= {d, y_q[(NUM_CH-1)*WIDTH-1:0]};
            end
        end
    end

    assign y    = y_q;
    assign chan = chan_reg;
    assign busy = (state_reg == ST_SCAN);

endmodule
